// File: rtl/ls_stream_ctrl_pkg.sv
// Shared sizing and state encoding for the local_store stream controller.
// Geometry comes from the array-wide L/WIDTH/B/ADDR_WIDTH macros.
`ifndef L
`define L 2
`endif
`ifndef WIDTH
`define WIDTH 8
`endif
`ifndef B
`define B 16
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 3
`endif

package ls_stream_ctrl_pkg;

  localparam int LS_LW    = `L * `WIDTH;
  localparam int LS_DEPTH = `B / `L;
  localparam int LS_AW    = `ADDR_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } ls_state_e;

  // Width of a counter that must be able to hold the value n.
  function automatic int ls_cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ls_skid2.sv
// Two-entry valid/ready output buffer with occupancy count.
// Head entry never moves while it is presented and not popped.
module ls_skid2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
  logic [1:0]   count_q, count_d;
  logic         pop_s, push_s;

  // Buffer next-state: push/pop in any combination, flush wins.
  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    count_d = count_q;
    pop_s   = pop_i & (count_q != 2'd0);
    push_s  = push_i & ((count_q != 2'd2) | pop_s);
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          if (count_q == 2'd0) begin
            ent0_d = data_i;
          end else begin
            ent1_d = data_i;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          ent0_d  = ent1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            ent0_d = data_i;
          end else begin
            ent0_d = ent1_q;
            ent1_d = data_i;
          end
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end
  end

  // Buffer storage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q  <= {W{1'b0}};
      ent1_q  <= {W{1'b0}};
      count_q <= 2'd0;
    end else begin
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      count_q <= count_d;
    end
  end

  assign valid_o = (count_q != 2'd0);
  assign data_o  = ent0_q;
  assign count_o = count_q;

endmodule

// File: rtl/ls_stream_ctrl.sv
// Load/drain stream controller for one local_store tile buffer.
// Drain path hides the store's one-cycle read latency behind a 2-entry skid.
module ls_stream_ctrl
  import ls_stream_ctrl_pkg::*;
#(
  parameter int LW    = LS_LW,
  parameter int DEPTH = LS_DEPTH,
  parameter int AW    = LS_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_start,
  input  logic          drain_start,
  input  logic [LW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [LW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          ls_we,
  output logic [AW-1:0] ls_a_w,
  output logic [LW-1:0] ls_di,
  output logic [AW-1:0] ls_a_r,
  input  logic [LW-1:0] ls_dout,
  output logic          busy,
  output logic          done
);

  localparam int CW = ls_cnt_width(DEPTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] LASTC_C  = CW'(DEPTH - 1);
  localparam logic [CW-1:0] ONEC_C   = CW'(1);
  localparam logic [AW-1:0] LASTP_C  = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ONEP_C   = AW'(1);

  ls_state_e     state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] issued_q, issued_d, popped_q, popped_d;
  logic          inflight_q, inflight_d;
  logic          done_q, done_d;

  logic          skid_valid_s, pop_s, issue_s, flush_s;
  logic [LW-1:0] skid_head_s;
  logic [1:0]    occ_s;
  logic [2:0]    pending_s;

  // Read issue: at most two words may be buffered or in flight after this cycle's pop.
  always_comb begin
    pop_s     = skid_valid_s & out_ready;
    pending_s = {1'b0, occ_s} + {2'b00, inflight_q} - {2'b00, pop_s};
    flush_s   = (state_q == ST_IDLE);
    if ((state_q == ST_DRAIN) && (issued_q < DEPTH_C) && (pending_s < 3'd2)) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
  end

  // FSM next-state, pointer and counter updates.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    issued_d   = issued_q;
    popped_d   = popped_q;
    done_d     = 1'b0;
    inflight_d = issue_s;
    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d = ST_LOAD;
        end else if (drain_start) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          if (wr_ptr_q == LASTP_C) begin
            state_d  = ST_IDLE;
            wr_ptr_d = {AW{1'b0}};
            done_d   = 1'b1;
          end else begin
            wr_ptr_d = wr_ptr_q + ONEP_C;
          end
        end else begin
          wr_ptr_d = wr_ptr_q;
        end
      end
      ST_DRAIN: begin
        if (issue_s) begin
          issued_d = issued_q + ONEC_C;
          if (rd_ptr_q != LASTP_C) begin
            rd_ptr_d = rd_ptr_q + ONEP_C;
          end else begin
            rd_ptr_d = rd_ptr_q;
          end
        end else begin
          issued_d = issued_q;
        end
        // The final pop can only follow the final issue, so it overrides the updates above.
        if (pop_s) begin
          if (popped_q == LASTC_C) begin
            state_d  = ST_IDLE;
            rd_ptr_d = {AW{1'b0}};
            issued_d = {CW{1'b0}};
            popped_d = {CW{1'b0}};
            done_d   = 1'b1;
          end else begin
            popped_d = popped_q + ONEC_C;
          end
        end else begin
          popped_d = popped_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      issued_q   <= {CW{1'b0}};
      popped_q   <= {CW{1'b0}};
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      issued_q   <= issued_d;
      popped_q   <= popped_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
    end
  end

  // Store port and stream handshake outputs, gated by state.
  always_comb begin
    if (state_q == ST_LOAD) begin
      in_ready = 1'b1;
      ls_we    = in_valid;
      ls_a_w   = wr_ptr_q;
      ls_di    = in_data;
    end else begin
      in_ready = 1'b0;
      ls_we    = 1'b0;
      ls_a_w   = {AW{1'b0}};
      ls_di    = {LW{1'b0}};
    end
    if (state_q == ST_DRAIN) begin
      ls_a_r = rd_ptr_q;
    end else begin
      ls_a_r = {AW{1'b0}};
    end
  end

  ls_skid2 #(.W(LW)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush_s),
    .push_i  (inflight_q),
    .data_i  (ls_dout),
    .pop_i   (pop_s),
    .valid_o (skid_valid_s),
    .data_o  (skid_head_s),
    .count_o (occ_s)
  );

  assign out_valid = skid_valid_s;
  assign out_data  = skid_head_s;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_ls_stream_ctrl.sv
// Scoreboard bench for ls_stream_ctrl paired with a registered-read store model.
module tb_ls_stream_ctrl;
  import ls_stream_ctrl_pkg::*;

  localparam int LW    = LS_LW;
  localparam int DEPTH = LS_DEPTH;
  localparam int AW    = LS_AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_start = 1'b0, drain_start = 1'b0;
  logic [LW-1:0] in_data = '0;
  logic          in_valid = 1'b0, in_ready;
  logic [LW-1:0] out_data;
  logic          out_valid, out_ready = 1'b0;
  logic          ls_we;
  logic [AW-1:0] ls_a_w, ls_a_r;
  logic [LW-1:0] ls_di, ls_dout;
  logic          busy, done;

  ls_stream_ctrl dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .drain_start(drain_start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .ls_we(ls_we), .ls_a_w(ls_a_w), .ls_di(ls_di), .ls_a_r(ls_a_r), .ls_dout(ls_dout),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // local_store: synchronous write, registered read address.
  logic [LW-1:0] store_mem [0:(1<<AW)-1];
  logic [AW-1:0] rd_addr_q = '0;
  always @(posedge clk) begin
    if (ls_we) store_mem[ls_a_w] <= ls_di;
    rd_addr_q <= ls_a_r;
  end
  assign ls_dout = store_mem[rd_addr_q];

  int            n_cmp = 0;
  int            n_bad = 0;
  int            pops  = 0;
  logic [LW-1:0] exp_q [$];
  logic [LW-1:0] model [DEPTH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops expected words on every output handshake and checks hold-while-stalled.
  logic          stall_q = 1'b0;
  logic [LW-1:0] stall_data_q = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_data", {16'd0, out_data}, {16'd0, stall_data_q});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_word: got 0x%0h expected none", out_data);
        end else begin
          check("out_word", {16'd0, out_data}, {16'd0, exp_q.pop_front()});
        end
        pops++;
      end
      stall_q      = out_valid && !out_ready;
      stall_data_q = out_data;
    end
  end

  task automatic do_load(input logic [LW-1:0] base, input bit gaps, input bit both_start,
                         input bit busy_drain);
    logic [7:0] gap_pat;
    gap_pat     = 8'b0110_1001;
    load_start  = 1'b1;
    drain_start = both_start;
    tick();
    load_start  = 1'b0;
    drain_start = 1'b0;
    check("load_busy", {31'd0, busy}, 32'd1);
    check("load_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      if (gaps && gap_pat[i % 8]) begin
        in_valid = 1'b0;
        tick();
        check("gap_no_we", {31'd0, ls_we}, 32'd0);
      end
      in_data     = base + LW'(i);
      in_valid    = 1'b1;
      drain_start = busy_drain && (i == 3);
      #1;
      check("we", {31'd0, ls_we}, 32'd1);
      check("a_w", 32'(ls_a_w), 32'(i));
      check("di", {16'd0, ls_di}, {16'd0, base + LW'(i)});
      model[i] = base + LW'(i);
      tick();
      in_valid    = 1'b0;
      drain_start = 1'b0;
    end
    check("load_done", {31'd0, done}, 32'd1);
    check("load_idle", {31'd0, busy}, 32'd0);
    tick();
    check("load_done_end", {31'd0, done}, 32'd0);
    check("stay_idle", {31'd0, busy}, 32'd0);
    check("no_drain", {31'd0, out_valid}, 32'd0);
  endtask

  // mode 0: out_ready held high; mode 1: out_ready pattern 1,0,0,1.
  task automatic do_drain(input int mode, input int abort_after);
    logic [3:0] rdy_pat;
    bit         got_done;
    int         cyc;
    rdy_pat     = 4'b1001;
    got_done    = 1'b0;
    cyc         = 0;
    out_ready   = (mode == 0);
    pops        = 0;
    drain_start = 1'b1;
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(model[i]);
    tick();
    drain_start = 1'b0;
    if (mode == 0 && abort_after == 0) begin
      check("lat_e0", {31'd0, out_valid}, 32'd0);
      tick();
      check("lat_e1", {31'd0, out_valid}, 32'd0);
      tick();
      check("lat_e2", {31'd0, out_valid}, 32'd1);
    end
    for (int c = 0; c < 200 && !got_done; c++) begin
      if (mode == 1) out_ready = rdy_pat[c % 4];
      if (abort_after > 0 && pops >= abort_after) begin
        rst_n = 1'b0;
        #1;
        check("abort_valid", {31'd0, out_valid}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
          tick();
          check("abort_no_done", {31'd0, done}, 32'd0);
          check("abort_idle", {31'd0, busy}, 32'd0);
        end
        return;
      end
      tick();
      cyc++;
      if (done) got_done = 1'b1;
    end
    check("drain_done_seen", {31'd0, got_done}, 32'd1);
    if (mode == 0) check("no_bubble_cycles", 32'(cyc), 32'(DEPTH));
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("pop_count", 32'(pops), 32'(DEPTH));
    tick();
    check("drain_done_end", {31'd0, done}, 32'd0);
    check("drain_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_we", {31'd0, ls_we}, 32'd0);
    check("rst_a_r", 32'(ls_a_r), 32'd0);
    rst_n = 1'b1;
    tick();

    do_load(LW'(1), 1'b0, 1'b0, 1'b0);
    do_drain(0, 0);
    do_drain(0, 3);
    do_drain(0, 0);

    do_load(LW'(16'h00A1), 1'b1, 1'b0, 1'b0);
    do_drain(1, 0);

    do_load(LW'(16'h0051), 1'b0, 1'b1, 1'b0);
    do_load(LW'(16'h0061), 1'b0, 1'b0, 1'b1);
    do_drain(0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ls_stream_ctrl.md
Name: ls_stream_ctrl

Overview:
- Streaming port controller for one local_store tile buffer.
- Load mode: accepts a valid/ready word stream and drives the store's write port (we, a_w, di) at sequential addresses.
- Drain mode: drives the store's read port (a_r), absorbs the store's one-cycle registered-address read latency, and presents the tile as a valid/ready output stream with full backpressure.
- Sits between the tile DMA/stream fabric and each local_store instance in the FW processing array.

Parameters:
- LW, `L*`WIDTH, stream and store word width (one row slice of L elements).
- DEPTH, `B/`L, words per tile; equals local_store size.
- AW, `ADDR_WIDTH, store address width; DEPTH <= 2**AW.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- load_start  in  1  one-cycle request to load a full tile; sampled only in IDLE.
- drain_start  in  1  one-cycle request to drain a full tile; sampled only in IDLE.
- in_data  in  LW  input stream word.
- in_valid  in  1  input word valid.
- in_ready  out  1  controller accepts the input word.
- out_data  out  LW  output stream word.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts the output word.
- ls_we  out  1  store write enable.
- ls_a_w  out  AW  store write address.
- ls_di  out  LW  store write data.
- ls_a_r  out  AW  store read address; the store registers it, and ls_dout is valid the following cycle.
- ls_dout  in  LW  store read data.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse when a load or drain completes.

Behaviour:
- Reset values: all outputs 0; state IDLE; wr_ptr, rd_ptr and issue count 0; skid buffer empty.
- States: IDLE, LOAD, DRAIN.
- IDLE:
  - load_start -> LOAD.
  - else drain_start -> DRAIN.
  - Both asserted in the same cycle: load wins; the drain request is dropped.
  - Starts while busy are ignored (not queued).
- LOAD:
  - in_ready = 1.
  - ls_we = in_valid, combinational; ls_a_w = wr_ptr; ls_di = in_data.
  - Each handshake increments wr_ptr. Gaps in in_valid stall with no write.
  - The handshake at wr_ptr = DEPTH-1 returns to IDLE. done pulses the next cycle; wr_ptr clears.
- DRAIN:
  - ls_a_r = rd_ptr.
  - A read is issued when issued < DEPTH and (buffer occupancy + in-flight - pop_this_cycle) < 2.
  - An issue at cycle t pushes ls_dout into the 2-entry output buffer at edge t+1.
  - out_valid = buffer non-empty; out_data = head entry.
  - Pop on out_valid & out_ready. Simultaneous push and pop is allowed.
- Drain latency and throughput:
  - out_valid first rises 2 cycles after the edge that samples drain_start.
  - With out_ready held at 1, one word per cycle.
  - out_ready may deassert arbitrarily. No word is lost or duplicated, and out_data is stable while out_valid & !out_ready.
- Drain completion: after DEPTH issues and the DEPTH-th pop -> IDLE; done pulses the next cycle; rd_ptr clears.
- Address arithmetic:
  - Pointers are AW bits and never exceed DEPTH-1.
  - Counters are sized to hold DEPTH.
  - No wrap within a tile.
- Outside DRAIN, ls_a_r holds 0. The drain skid buffer is empty whenever the block is in IDLE.
- Reset mid-operation:
  - Asynchronous abort to IDLE; buffer flushed; no done pulse.
  - Partially written store contents are left as they are.

Decomposition:
- Shared package/params include: LW, DEPTH and AW derived from `L, `WIDTH, `B and `ADDR_WIDTH; state encoding constants for IDLE, LOAD and DRAIN.
- One natural sub-module: ls_skid2, a 2-entry valid/ready output buffer with occupancy count. The FSM and pointers stay in ls_stream_ctrl.
- Bench pairs the block with a real local_store instance.

Test Plan:
- Load, then drain with no backpressure: load_start, then DEPTH words 0x1..DEPTH with in_valid steady; then drain_start, out_ready=1.
  -> done 1 cycle after the last write; out_valid 2 cycles after the drain start edge; words 0x1..DEPTH back-to-back; done after the last pop.
- Random gaps on both sides: in_valid 50% gaps during load; out_ready toggled 1,0,0,1,... during drain.
  -> exact in-order sequence out; out_data held stable while stalled; never more than 2 reads outstanding.
- Simultaneous starts: load_start=drain_start=1 in IDLE.
  -> enters LOAD; drain ignored; busy=1 until the load's done.
- Start while busy: drain_start pulsed mid-load.
  -> ignored; after the load's done, state is IDLE with no drain.
- Reset mid-drain: rst_n=0 after 3 pops of DEPTH.
  -> immediate out_valid=0, busy=0, no done; a subsequent drain_start streams from address 0 (word 0x1).
- Single-cycle pop/push overlap: out_ready=1 with buffer at occupancy 1 each cycle.
  -> sustained 1 word/cycle, with no bubbles after the first valid.
